// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - ID-stage request / hazard-and-forwarding response bundle
//
// Purpose: groups the ID-stage instruction fields and pipeline control inputs
// with the forwarding selects, stall/bubble controls and stall counter
// returned by hazard_fwd_unit.
// Ports (master drives, slave receives):
//   freeze, ex_flush            pipeline hold / EX-resolved squash
//   id_valid, id_rs1, id_rs2    ID instruction presence and sources
//   id_use_rs1, id_use_rs2      ID instruction actually reads rs1/rs2
//   id_rd, id_reg_write         ID destination and write enable
//   id_mem_read                 ID instruction is a load
// Ports (slave drives, master receives):
//   fwd_sel_a, fwd_sel_b        EX operand mux selects (00 RF, 01 MEM, 10 WB)
//   stall, bubble_ex            hold PC+IF/ID, load NOP into ID/EX
//   load_use_cnt                saturating load-use stall count
interface hazard_fwd_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  freeze;
  logic                  ex_flush;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic [1:0]            fwd_sel_a;
  logic [1:0]            fwd_sel_b;
  logic                  stall;
  logic                  bubble_ex;
  logic [CNT_W-1:0]      load_use_cnt;

  modport master (
    output freeze, ex_flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read,
    input  fwd_sel_a, fwd_sel_b, stall, bubble_ex, load_use_cnt
  );

  modport slave (
    input  freeze, ex_flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read,
    output fwd_sel_a, fwd_sel_b, stall, bubble_ex, load_use_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - 5-stage pipeline load-use hazard and EX operand forwarding controller
//
// Purpose: shadows destination-register state of the EX and MEM stages,
// registers the EX operand forwarding selects as each instruction enters EX,
// detects load-use hazards (one-cycle stall + EX bubble) and counts them.
// Ports:
//   clk  core clock, rising-edge state updates
//   rst  synchronous active-high reset
//   bus  hazard_fwd_unit_if.slave: ID fields and controls in, selects/stall out
module hazard_fwd_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_fwd_unit_if.slave    bus
);

  // The WB stage's writer is never consulted: WB forwarding is chosen from
  // the MEM slot at the edge the producer moves MEM->WB, so only EX and MEM
  // destination state needs to be retained.
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_rw_q, ex_rw_d;
  logic                  ex_mr_q, ex_mr_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [1:0]            sel_a_q, sel_a_d;
  logic [1:0]            sel_b_q, sel_b_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic ex_p1, ex_p2, mem_p1, mem_p2;
  logic hz, bubble;

  // x0 is hardwired zero: never a forwarding source, never a hazard.
  function automatic logic produces(input logic v, input logic rw,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] r);
    return v && rw && (rd == r) && (r != '0);
  endfunction

  assign ex_p1  = produces(ex_valid_q,  ex_rw_q,  ex_rd_q,  bus.id_rs1);
  assign ex_p2  = produces(ex_valid_q,  ex_rw_q,  ex_rd_q,  bus.id_rs2);
  assign mem_p1 = produces(mem_valid_q, mem_rw_q, mem_rd_q, bus.id_rs1);
  assign mem_p2 = produces(mem_valid_q, mem_rw_q, mem_rd_q, bus.id_rs2);

  // A flush squashes the dependent instruction, so the hazard is moot.
  assign hz = bus.id_valid && ex_mr_q && !bus.ex_flush &&
              ((bus.id_use_rs1 && ex_p1) || (bus.id_use_rs2 && ex_p2));
  assign bubble = hz || bus.ex_flush;

  assign bus.stall        = hz;
  assign bus.bubble_ex    = bubble;
  assign bus.fwd_sel_a    = sel_a_q;
  assign bus.fwd_sel_b    = sel_b_q;
  assign bus.load_use_cnt = cnt_q;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rd_d     = ex_rd_q;
    ex_rw_d     = ex_rw_q;
    ex_mr_d     = ex_mr_q;
    mem_valid_d = mem_valid_q;
    mem_rd_d    = mem_rd_q;
    mem_rw_d    = mem_rw_q;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    cnt_d       = cnt_q;
    if (!bus.freeze) begin
      mem_valid_d = ex_valid_q;
      mem_rd_d    = ex_rd_q;
      mem_rw_d    = ex_rw_q;
      if (bubble) begin
        ex_valid_d = 1'b0;
        ex_rd_d    = '0;
        ex_rw_d    = 1'b0;
        ex_mr_d    = 1'b0;
        sel_a_d    = 2'b00;
        sel_b_d    = 2'b00;
      end else begin
        ex_valid_d = bus.id_valid;
        ex_rd_d    = bus.id_rd;
        ex_rw_d    = bus.id_reg_write;
        ex_mr_d    = bus.id_mem_read;
        // Current EX becomes MEM (01), current MEM becomes WB (10);
        // checking EX first makes the youngest writer win.
        sel_a_d = !bus.id_use_rs1 ? 2'b00 : ex_p1 ? 2'b01 : mem_p1 ? 2'b10 : 2'b00;
        sel_b_d = !bus.id_use_rs2 ? 2'b00 : ex_p2 ? 2'b01 : mem_p2 ? 2'b10 : 2'b00;
      end
      if (hz && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      sel_a_q     <= 2'b00;
      sel_b_q     <= 2'b00;
      cnt_q       <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_rw_q    <= mem_rw_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed-vector bench for hazard_fwd_unit
module tb_hazard_fwd_unit;
  logic clk = 1'b0;
  logic rst;
  logic freeze, ex_flush, id_valid, use1, use2, rw, mr;
  logic [4:0] rs1, rs2, rd;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();
  hazard_fwd_unit_if #(.REG_ADDR_W(5), .CNT_W(2))  bus2 ();

  assign bus.freeze  = freeze;   assign bus2.freeze  = freeze;
  assign bus.ex_flush = ex_flush; assign bus2.ex_flush = ex_flush;
  assign bus.id_valid = id_valid; assign bus2.id_valid = id_valid;
  assign bus.id_rs1 = rs1;        assign bus2.id_rs1 = rs1;
  assign bus.id_rs2 = rs2;        assign bus2.id_rs2 = rs2;
  assign bus.id_use_rs1 = use1;   assign bus2.id_use_rs1 = use1;
  assign bus.id_use_rs2 = use2;   assign bus2.id_use_rs2 = use2;
  assign bus.id_rd = rd;          assign bus2.id_rd = rd;
  assign bus.id_reg_write = rw;   assign bus2.id_reg_write = rw;
  assign bus.id_mem_read = mr;    assign bus2.id_mem_read = mr;

  hazard_fwd_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  hazard_fwd_unit #(.REG_ADDR_W(5), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] a, input logic ua,
                        input logic [4:0] b, input logic ub,
                        input logic [4:0] d, input logic w, input logic m);
    id_valid = v; rs1 = a; use1 = ua; rs2 = b; use2 = ub; rd = d; rw = w; mr = m;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    tick(); tick(); tick();
  endtask

  task automatic chk_sel(input string name, input logic [1:0] ea, input logic [1:0] eb);
    vectors++;
    if (bus.fwd_sel_a !== ea) begin miscompares++; $display("FAIL %s sel_a: got %b expected %b", name, bus.fwd_sel_a, ea); end
    vectors++;
    if (bus.fwd_sel_b !== eb) begin miscompares++; $display("FAIL %s sel_b: got %b expected %b", name, bus.fwd_sel_b, eb); end
  endtask

  task automatic chk_ctl(input string name, input logic es, input logic eb);
    vectors++;
    if (bus.stall !== es) begin miscompares++; $display("FAIL %s stall: got %b expected %b", name, bus.stall, es); end
    vectors++;
    if (bus.bubble_ex !== eb) begin miscompares++; $display("FAIL %s bubble_ex: got %b expected %b", name, bus.bubble_ex, eb); end
  endtask

  task automatic chk_cnt(input string name, input int e16, input int e2);
    vectors++;
    if (bus.load_use_cnt !== 16'(e16)) begin miscompares++; $display("FAIL %s cnt16: got %0d expected %0d", name, bus.load_use_cnt, e16); end
    vectors++;
    if (bus2.load_use_cnt !== 2'(e2)) begin miscompares++; $display("FAIL %s cnt2: got %0d expected %0d", name, bus2.load_use_cnt, e2); end
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; ex_flush = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_sel("reset", 2'b00, 2'b00);
    chk_ctl("reset", 1'b0, 1'b0);
    chk_cnt("reset", 0, 0);
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);   // sub x8, x5, x6
    chk_ctl("b2b_id", 1'b0, 1'b0);
    tick();
    idle();
    chk_sel("b2b_ex", 2'b01, 2'b00);
    chk_ctl("b2b_after", 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_distance2();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);   // add x7
    tick();
    idle();                                                    // nop
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);   // or x9, x1, x7
    chk_ctl("dist2_id", 1'b0, 1'b0);
    tick();
    idle();
    chk_sel("dist2_ex", 2'b00, 2'b10);
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);   // lw x3
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);   // add x9, x3
    chk_ctl("lu_n", 1'b1, 1'b1);
    chk_cnt("lu_n", 0, 0);
    tick();
    chk_ctl("lu_n1", 1'b0, 1'b0);
    chk_cnt("lu_n1", 1, 1);
    tick();
    idle();
    chk_sel("lu_ex", 2'b10, 2'b00);
    drain();
  endtask

  task automatic test_x0_nouse();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // lw x0
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);   // reader of x0
    chk_ctl("x0_id", 1'b0, 1'b0);
    tick();
    idle();
    chk_sel("x0_ex", 2'b00, 2'b00);
    drain();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);   // lw x4
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd4, 1'b0, 5'd10, 1'b1, 1'b0);  // rs2=x4 unused
    chk_ctl("nouse_id", 1'b0, 1'b0);
    tick();
    idle();
    chk_sel("nouse_ex", 2'b00, 2'b00);
    chk_cnt("x0_nouse", 1, 1);
    drain();
  endtask

  task automatic test_flush_hz();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);   // lw x3
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);   // add x9, x3
    ex_flush = 1'b1;
    #1;
    chk_ctl("flush_hz", 1'b0, 1'b1);
    tick();
    ex_flush = 1'b0;
    idle();
    chk_cnt("flush_hz", 1, 1);
    chk_sel("flush_bubble", 2'b00, 2'b00);
    drain();
  endtask

  task automatic test_freeze();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);   // add x2
    tick();
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);   // lw x6, 0(x2)
    tick();
    chk_sel("frz_lw_ex", 2'b01, 2'b00);
    set_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd10, 1'b1, 1'b0);  // add x10, x6
    chk_ctl("frz_pre", 1'b1, 1'b1);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ctl("frz_hold", 1'b1, 1'b1);
      chk_sel("frz_hold", 2'b01, 2'b00);
      chk_cnt("frz_hold", 1, 1);
    end
    freeze = 1'b0;
    tick();
    chk_ctl("frz_release", 1'b0, 1'b0);
    chk_cnt("frz_release", 2, 2);
    chk_sel("frz_bubble", 2'b00, 2'b00);
    tick();
    idle();
    chk_sel("frz_dep_ex", 2'b00, 2'b10);
    drain();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 2; k++) begin
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
      tick();
      tick();
      drain();
      chk_cnt("saturate", 3 + k, 3);
    end
  endtask

  task automatic test_reset_mid();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);  // add x11
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);  // lw x12
    tick();
    set_id(1'b1, 5'd12, 1'b1, 5'd11, 1'b1, 5'd13, 1'b1, 1'b0);
    chk_ctl("rstmid_pre", 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_sel("rstmid", 2'b00, 2'b00);
    chk_cnt("rstmid", 0, 0);
    chk_ctl("rstmid", 1'b0, 1'b0);
    tick();
    idle();
    chk_sel("rstmid_dep", 2'b00, 2'b00);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance2();
    test_load_use();
    test_x0_nouse();
    test_flush_hz();
    test_freeze();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
